// File: rtl/lfsr_pkg.sv
// Shared definitions for the 5-bit PRBS generator and checker: width, seed, states, step function.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 5;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 5'h01;

  typedef enum logic [1:0] {
    StHunt,
    StVerify,
    StLocked
  } chk_state_e;

  // Maximal-length sequence, period 31; the all-zero state is never reached.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[3:0], v[4] ^ v[2]};
  endfunction

endpackage

// File: rtl/lfsr_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module lfsr_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// PRBS-5 checker: hunts for a seed, verifies LOCK_CNT matches, then free-runs and counts errors.
// Error statistics (err_cnt, clr_err) are built only with LFSR_CHECKER_STATS_EN defined.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned LOSS_CNT = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_data,
  input  logic              clr_err,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam logic [3:0] LockCnt = 4'(LOCK_CNT);
  localparam logic [3:0] LossCnt = 4'(LOSS_CNT);

  chk_state_e        state;
  logic [LFSR_W-1:0] expected;
  logic [3:0]        match_cnt;
  logic [3:0]        miss_cnt;
  logic              mismatch;
  logic              err_inc;

  assign mismatch = (in_data != expected);
  assign err_inc  = in_valid && (state == StLocked) && mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StHunt;
      expected  <= LFSR_SEED;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= err_inc;
      if (in_valid) begin
        case (state)
          StHunt: begin
            if (in_data != '0) begin
              expected  <= lfsr_next(in_data);
              match_cnt <= '0;
              state     <= StVerify;
            end
          end
          StVerify: begin
            if (in_data == '0) begin
              state <= StHunt;
            end else if (!mismatch) begin
              expected <= lfsr_next(expected);
              if (match_cnt + 4'd1 == LockCnt) begin
                state    <= StLocked;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end else begin
                match_cnt <= match_cnt + 4'd1;
              end
            end else begin
              expected  <= lfsr_next(in_data);
              match_cnt <= '0;
            end
          end
          StLocked: begin
            // Flywheel: never re-seed from received data once locked.
            expected <= lfsr_next(expected);
            if (mismatch) begin
              if (miss_cnt + 4'd1 == LossCnt) begin
                state    <= StHunt;
                locked   <= 1'b0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + 4'd1;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: state <= StHunt;
        endcase
      end
    end
  end

`ifdef LFSR_CHECKER_STATS_EN
  lfsr_sat_cnt #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_err),
    .inc  (err_inc),
    .cnt  (err_cnt)
  );
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: directed lock/error/loss/gap cases, random traffic, async reset.
module tb_lfsr_checker;

  localparam int LOCK = 3;
  localparam int LOSS = 4;
  localparam int ERRW = 2;
  localparam int ERR_MAX = (1 << ERRW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [4:0]      in_data;
  logic            clr_err;
  logic            locked;
  logic            err_pulse;
  logic [ERRW-1:0] err_cnt;

  lfsr_checker #(
    .LOCK_CNT(LOCK),
    .LOSS_CNT(LOSS),
    .ERR_W   (ERRW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .clr_err  (clr_err),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lk;
    int ep;
    int ec;
    int id;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_step = 0;

  // Reference model state: mode 0 = hunting, 1 = verifying, 2 = locked.
  int m_mode, m_exp, m_match, m_miss, m_err, m_lk, m_ep;

  function automatic int ref_next(int v);
    return ((v * 2) % 32) + (((v / 16) + (v / 4)) % 2);
  endfunction

  task automatic chk(string name, int id, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0d, expected %0d", name, id, act, req);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_exp = 1; m_match = 0; m_miss = 0; m_err = 0; m_lk = 0; m_ep = 0;
  endtask

  task automatic model_step(bit v, int d, bit c);
    bit miss;
    m_ep = 0;
    if (v) begin
      if (m_mode == 0) begin
        if (d != 0) begin
          m_exp = ref_next(d); m_match = 0; m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (d == 0) m_mode = 0;
        else if (d == m_exp) begin
          m_match++;
          m_exp = ref_next(m_exp);
          if (m_match == LOCK) begin
            m_mode = 2; m_lk = 1; m_miss = 0;
          end
        end else begin
          m_exp = ref_next(d); m_match = 0;
        end
      end else begin
        miss  = (d != m_exp);
        m_exp = ref_next(m_exp);
        if (miss) begin
          m_ep = 1;
          m_miss++;
          if (m_err < ERR_MAX) m_err++;
          if (m_miss == LOSS) begin
            m_mode = 0; m_lk = 0; m_miss = 0;
          end
        end else m_miss = 0;
      end
    end
    if (c) m_err = 0;
  endtask

  // Apply one cycle of input; expected outputs are queued once the edge has happened.
  task automatic step(bit v, int d, bit c);
    exp_t e;
    in_valid = v;
    in_data  = 5'(d);
    clr_err  = c;
    model_step(v, d, c);
    e.lk = m_lk;
    e.ep = m_ep;
`ifdef LFSR_CHECKER_STATS_EN
    e.ec = m_err;
`else
    e.ec = 0;
`endif
    e.id = n_step++;
    @(posedge clk);
    #1;
    q.push_back(e);
    in_valid = 1'b0;
    clr_err  = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) step(0, int'($urandom_range(0, 31)), 0);
  endtask

  task automatic feed(int vals[]);
    foreach (vals[i]) step(1, vals[i], 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("locked", e.id, 32'(locked), 32'(e.lk));
        chk("err_pulse", e.id, 32'(err_pulse), 32'(e.ep));
        chk("err_cnt", e.id, 32'(err_cnt), 32'(e.ec));
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int d;
    bit v, c;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    clr_err  = 1'b0;
    model_reset();
    #12;
    chk("reset_locked", -1, 32'(locked), 0);
    chk("reset_err_pulse", -1, 32'(err_pulse), 0);
    chk("reset_err_cnt", -1, 32'(err_cnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Lock acquisition, then clean locked samples.
    feed('{1, 2, 4, 9, 18, 5, 11});
    // Single error with 22 expected, then the flywheel value 12.
    feed('{23, 12});
    idle(2);
    // Loss of lock on four zeros, then zeros keep it hunting.
    feed('{0, 0, 0, 0, 0, 0, 0});
    // Seed to 4 expected, wrong sample re-seeds, gap, then lock.
    feed('{2, 7});
    idle(3);
    feed('{15, 31, 30});

    // Five errors without losing lock: saturate, then clear against an error.
    for (int i = 0; i < 7; i++) begin
      if (i == 2 || i == 5) step(1, m_exp, 0);
      else step(1, m_exp ^ 16, 0);
    end
    step(1, m_exp ^ 1, 1);
    step(1, m_exp, 0);

    for (int i = 0; i < 1500; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 9) < 7) ? m_exp : int'($urandom_range(0, 31));
      c = v && ($urandom_range(0, 49) == 0);
      step(v, d, c);
    end

    // Async reset mid-lock, between clock edges.
    feed('{1, 2, 4, 9});
    step(1, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_locked", -2, 32'(locked), 0);
    chk("async_err_cnt", -2, 32'(err_cnt), 0);
    chk("async_err_pulse", -2, 32'(err_pulse), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    feed('{1, 2, 4, 9, 18});

    repeat (3) @(posedge clk);
    chk("queue_drained", -3, 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
